data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 28 ++
 rtl/data_mem_responder_if.sv | 34 +++
 rtl/mem_byte_bank.sv | 31 +++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data memory responder: FSM states, byte lanes, word layout.
// Latency: none (types and a pure combinational helper only).
// Backpressure: not applicable.
package mem_pkg;

    localparam int LANES = 4;

    typedef logic [7:0]       byte_t;
    // Lane 0 sits in bits [7:0] and maps to the lowest byte address.
    typedef byte_t [LANES-1:0] word_t;
    typedef logic [LANES-1:0]  strobe_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Per-lane select between the stored word and incoming write data.
    function automatic word_t merge_lanes(word_t old_w, word_t new_w, strobe_t be);
        word_t r;
        for (int k = 0; k < LANES; k++) begin
            r[k] = be[k] ? new_w[k] : old_w[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-memory request/response bundle; the mem_byte_en strobe exists only with MEM_BYTE_STROBE_EN.
// Latency: none (wiring only).
// Backpressure: core holds mem_req until a one-cycle mem_ready pulse.
interface data_mem_responder_if;
    import mem_pkg::*;

    logic        mem_req;
    logic [31:0] mem_addr;
    word_t       mem_data_in;
    logic        mem_write_en;
`ifdef MEM_BYTE_STROBE_EN
    strobe_t     mem_byte_en;
`endif
    word_t       mem_data_out;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output mem_req, mem_addr, mem_data_in, mem_write_en,
`ifdef MEM_BYTE_STROBE_EN
        output mem_byte_en,
`endif
        input  mem_data_out, mem_ready, mem_err
    );

    modport slave (
        input  mem_req, mem_addr, mem_data_in, mem_write_en,
`ifdef MEM_BYTE_STROBE_EN
        input  mem_byte_en,
`endif
        output mem_data_out, mem_ready, mem_err
    );

endinterface

// File: rtl/mem_byte_bank.sv
// Word storage split into byte lanes with independent write enables.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none; accepts a write every cycle.
module mem_byte_bank
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  strobe_t       wr_en_i,
    input  word_t         wr_dat_i,
    output word_t         rd_dat_o
);

    // Contents are deliberately not reset.
    word_t mem_q [DEPTH_WORDS];

    // Lane-wise synchronous write.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (wr_en_i[k]) begin
                mem_q[addr_i][k] <= wr_dat_i[k];
            end
        end
    end

    assign rd_dat_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder: accepts one core request, answers after LATENCY cycles.
// Latency: mem_ready pulses on the LATENCY-th cycle after the accepting edge; MEM_BYTE_STROBE_EN enables lane strobes.
// Backpressure: requests are only taken in IDLE; a held mem_req is ignored until the FSM returns to IDLE.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst_b,
    data_mem_responder_if.slave  bus
);

    localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    word_t          wdat_q, wdat_d;
    logic           wr_q, wr_d;
    strobe_t        be_q, be_d;
    logic           err_q, err_d;
    word_t          dout_q, dout_d;

    strobe_t        be_in;
    logic           req_err;
    word_t          rd_word;
    word_t          resp_word;
    strobe_t        bank_we;

`ifdef MEM_BYTE_STROBE_EN
    assign be_in = bus.mem_byte_en;
`else
    assign be_in = '1;
`endif

    // Misalignment and range are judged once, on the raw address at acceptance.
    assign req_err = (bus.mem_addr[1:0] != 2'b00) ||
                     ({2'b00, bus.mem_addr[31:2]} >= 32'(DEPTH_WORDS));

    // Response word: written words echo the merged result, errors read as zero.
    assign resp_word = err_q ? '0 :
                       (wr_q ? merge_lanes(rd_word, wdat_q, be_q) : rd_word);

    // Commit on the edge closing RESP, unless reset wipes the request on that edge.
    assign bank_we = (state_q == RESP && wr_q && !err_q && !rst_b) ? be_q : '0;

    mem_byte_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bank (
        .clk      (clk),
        .addr_i   (addr_q),
        .wr_en_i  (bank_we),
        .wr_dat_i (wdat_q),
        .rd_dat_o (rd_word)
    );

    // Next-state: accept in IDLE, count down in WAIT, answer for one cycle in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        wr_d    = wr_q;
        be_d    = be_q;
        err_d   = err_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    addr_d = bus.mem_addr[AW+1:2];
                    wdat_d = bus.mem_data_in;
                    wr_d   = bus.mem_write_en;
                    be_d   = be_in;
                    err_d  = req_err;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                dout_d  = resp_word;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.mem_ready    = (state_q == RESP);
    assign bus.mem_err      = (state_q == RESP) && err_q;
    assign bus.mem_data_out = (state_q == RESP) ? resp_word : dout_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 and LATENCY=1 instances with a response scoreboard.
// Latency: checks the exact response cycle of every transaction.
// Backpressure: mem_req is held until mem_ready, with bounded waits.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic        req_a, req_b;
    logic [31:0] addr, wdat;
    logic        we;
`ifdef MEM_BYTE_STROBE_EN
    logic [3:0]  be;
`endif

    data_mem_responder_if if_a ();
    data_mem_responder_if if_b ();

    assign if_a.mem_req      = req_a;
    assign if_a.mem_addr     = addr;
    assign if_a.mem_data_in  = wdat;
    assign if_a.mem_write_en = we;
    assign if_b.mem_req      = req_b;
    assign if_b.mem_addr     = addr;
    assign if_b.mem_data_in  = wdat;
    assign if_b.mem_write_en = we;
`ifdef MEM_BYTE_STROBE_EN
    assign if_a.mem_byte_en  = be;
    assign if_b.mem_byte_en  = be;
`endif

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut_a (
        .clk (clk), .rst_b (rst_b), .bus (if_a.slave));
    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut_b (
        .clk (clk), .rst_b (rst_b), .bus (if_b.slave));

    typedef struct {
        logic [31:0] dat;
        logic        err;
        string       nm;
    } exp_t;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int which, input logic v);
        if (which == 0) req_a = v; else req_b = v;
    endtask

    task automatic sample(input int which, output logic rdy, output logic er, output logic [31:0] d);
        if (which == 0) begin
            rdy = if_a.mem_ready; er = if_a.mem_err; d = if_a.mem_data_out;
        end else begin
            rdy = if_b.mem_ready; er = if_b.mem_err; d = if_b.mem_data_out;
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        we = w; addr = a; wdat = d;
`ifdef MEM_BYTE_STROBE_EN
        be = b;
`else
        if (b == 4'hx) we = w;
`endif
    endtask

    // One full transaction: drive, wait bounded for mem_ready, score it, check the hold cycle.
    task automatic xact(input int which, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] ed, input logic ee, input string nm);
        exp_t e;
        int cyc;
        logic rdy, er;
        logic [31:0] dq;
        e.dat = ed; e.err = ee; e.nm = nm;
        sb_q.push_back(e);
        @(negedge clk);
        drive(w, a, d, b);
        set_req(which, 1'b1);
        @(posedge clk);
        cyc = 0; rdy = 1'b0; er = 1'b0; dq = '0;
        while (!rdy && cyc < 16) begin
            @(negedge clk);
            cyc++;
            sample(which, rdy, er, dq);
        end
        set_req(which, 1'b0);
        e = sb_q.pop_front();
        if (!rdy) begin
            n_vec++; n_bad++;
            $display("FAIL %s timeout: no mem_ready within %0d cycles", e.nm, cyc);
        end else begin
            chk({e.nm, " latency"}, 32'(cyc), (which == 0) ? 32'd2 : 32'd1);
            chk({e.nm, " data"}, dq, e.dat);
            chk({e.nm, " err"}, {31'd0, er}, {31'd0, e.err});
        end
        @(negedge clk);
        sample(which, rdy, er, dq);
        chk({e.nm, " ready drop"}, {31'd0, rdy}, 32'd0);
        chk({e.nm, " err drop"}, {31'd0, er}, 32'd0);
        chk({e.nm, " data hold"}, dq, e.dat);
    endtask

    initial begin
        logic rdy, er;
        logic [31:0] dq;
        int pulses, at;
        logic strobe;
`ifdef MEM_BYTE_STROBE_EN
        strobe = 1'b1;
`else
        strobe = 1'b0;
`endif
        rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'hF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample(0, rdy, er, dq);
        chk("reset A ready", {31'd0, rdy}, 32'd0);
        chk("reset A err", {31'd0, er}, 32'd0);
        chk("reset A data", dq, 32'd0);
        sample(1, rdy, er, dq);
        chk("reset B ready", {31'd0, rdy}, 32'd0);
        chk("reset B data", dq, 32'd0);
        rst_b = 1'b0;

        vecs.push_back('{1'b1, 32'h40,   32'h11223344, 4'hF, 32'h11223344, 1'b0});
        vecs.push_back('{1'b0, 32'h40,   32'h0,        4'hF, 32'h11223344, 1'b0});
        vecs.push_back('{1'b1, 32'h44,   32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b0, 32'h44,   32'h0,        4'hF, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b1, 32'h24,   32'h76543210, 4'hF, 32'h76543210, 1'b0});
        vecs.push_back('{1'b0, 32'h42,   32'h0,        4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h1000, 32'h0,        4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h1000, 32'h55555555, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h41,   32'h66666666, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h40,   32'h0,        4'hF, 32'h11223344, 1'b0});
        vecs.push_back('{1'b1, 32'hFFC,  32'h0BADF00D, 4'hF, 32'h0BADF00D, 1'b0});
        vecs.push_back('{1'b0, 32'hFFC,  32'h0,        4'hF, 32'h0BADF00D, 1'b0});
        vecs.push_back('{1'b1, 32'h10,   32'hAABBCCDD, 4'hF, 32'hAABBCCDD, 1'b0});
        vecs.push_back('{1'b1, 32'h10,   32'h11223344, 4'b0101,
                         strobe ? 32'hAA22CC44 : 32'h11223344, 1'b0});
        vecs.push_back('{1'b0, 32'h10,   32'h0,        4'hF,
                         strobe ? 32'hAA22CC44 : 32'h11223344, 1'b0});
        vecs.push_back('{1'b1, 32'h10,   32'h99999999, 4'b0000,
                         strobe ? 32'hAA22CC44 : 32'h99999999, 1'b0});
        vecs.push_back('{1'b0, 32'h10,   32'h0,        4'hF,
                         strobe ? 32'hAA22CC44 : 32'h99999999, 1'b0});
        vecs.push_back('{1'b1, 32'h8,    32'h12345678, 4'hF, 32'h12345678, 1'b0});

        foreach (vecs[i]) begin
            xact(0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, vecs[i].ed, vecs[i].ee,
                 $sformatf("vec%0d", i));
        end

        // Reset in WAIT: pending write is dropped, no response.
        @(negedge clk);
        drive(1'b1, 32'h8, 32'hDEADBEEF, 4'hF); req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1; req_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        pulses = 0;
        repeat (4) begin
            sample(0, rdy, er, dq);
            if (rdy) pulses++;
            @(negedge clk);
        end
        chk("rst in WAIT pulses", 32'(pulses), 32'd0);
        chk("rst in WAIT data", dq, 32'd0);
        xact(0, 1'b0, 32'h8, 32'h0, 4'hF, 32'h12345678, 1'b0, "rd after WAIT rst");

        // Reset on the edge closing RESP: the write must not commit.
        @(negedge clk);
        drive(1'b1, 32'h8, 32'hCAFEBABE, 4'hF); req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        sample(0, rdy, er, dq);
        chk("rst in RESP ready", {31'd0, rdy}, 32'd1);
        rst_b = 1'b1; req_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        sample(0, rdy, er, dq);
        chk("rst in RESP after", {31'd0, rdy}, 32'd0);
        xact(0, 1'b0, 32'h8, 32'h0, 4'hF, 32'h12345678, 1'b0, "rd after RESP rst");

        // Inputs changed during WAIT must not affect a read.
        @(negedge clk);
        drive(1'b0, 32'h40, 32'h0, 4'hF); req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 32'h44, 32'hFFFFFFFF, 4'hF);
        at = 1; sample(0, rdy, er, dq);
        while (!rdy && at < 16) begin @(negedge clk); at++; sample(0, rdy, er, dq); end
        req_a = 1'b0;
        chk("wait-change rd latency", 32'(at), 32'd2);
        chk("wait-change rd data", dq, 32'h11223344);
        chk("wait-change rd err", {31'd0, er}, 32'd0);
        xact(0, 1'b0, 32'h44, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, "0x44 untouched");

        // Inputs changed during WAIT must not redirect a write.
        @(negedge clk);
        drive(1'b1, 32'h20, 32'hA1A2A3A4, 4'hF); req_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 32'h24, 32'hB1B2B3B4, 4'h0);
        at = 1; sample(0, rdy, er, dq);
        while (!rdy && at < 16) begin @(negedge clk); at++; sample(0, rdy, er, dq); end
        req_a = 1'b0;
        chk("wait-change wr data", dq, 32'hA1A2A3A4);
        xact(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'hA1A2A3A4, 1'b0, "rd 0x20");
        xact(0, 1'b0, 32'h24, 32'h0, 4'hF, 32'h76543210, 1'b0, "rd 0x24");

        // LATENCY=1: held request yields exactly one pulse.
        xact(1, 1'b1, 32'h0, 32'h5A5A1234, 4'hF, 32'h5A5A1234, 1'b0, "L1 wr 0x0");
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 4'hF); req_b = 1'b1;
        pulses = 0; at = -1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 2) req_b = 1'b0;
            sample(1, rdy, er, dq);
            if (rdy) begin
                pulses++;
                at = c;
                chk("L1 hold data", dq, 32'h5A5A1234);
            end
        end
        req_b = 1'b0;
        chk("L1 hold pulses", 32'(pulses), 32'd1);
        chk("L1 hold pulse cycle", 32'(at), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
